// File: rtl/pixel_frame_src.sv
// rtl/pixel_frame_src.sv - frame-buffer pixel source emitting a valid/ready pixel stream
//
// Sweeps a row-major IMG_W x IMG_H image memory and streams NCH channels of DW
// bits per pixel, with sof/eol/eof markers, backpressure and start/stop control.
//
// Ports:
//   sys_clk_i, sys_rst_ni    clock, asynchronous active-low reset
//   start_i, stop_i          begin streaming (IDLE only) / end continuous run at frame boundary
//   mem_en_o, mem_addr_o     memory read request
//   mem_rdata_i              memory read data, valid RD_LAT cycles after mem_en_o
//   pix_data_o, pix_valid_o, pix_ready_i   pixel stream handshake
//   pix_sof_o, pix_eol_o, pix_eof_o        markers qualified by pix_valid_o
//   busy_o, frame_done_o     status: not idle / eof pixel accepted last cycle
module pixel_frame_src #(
  parameter int IMG_W      = 160,
  parameter int IMG_H      = 120,
  parameter int NCH        = 3,
  parameter int DW         = 8,
  parameter int AW         = 15,
  parameter int RD_LAT     = 1,
  parameter int CONTINUOUS = 0
) (
  input  logic              sys_clk_i,
  input  logic              sys_rst_ni,
  input  logic              start_i,
  input  logic              stop_i,
  output logic              mem_en_o,
  output logic [AW-1:0]     mem_addr_o,
  input  logic [NCH*DW-1:0] mem_rdata_i,
  output logic [NCH*DW-1:0] pix_data_o,
  output logic              pix_valid_o,
  input  logic              pix_ready_i,
  output logic              pix_sof_o,
  output logic              pix_eol_o,
  output logic              pix_eof_o,
  output logic              busy_o,
  output logic              frame_done_o
);

  localparam int FIFO_DEPTH = RD_LAT + 2;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam int EW = NCH * DW + 3;
  localparam bit CONT = (CONTINUOUS != 0);

  localparam logic [XW-1:0] COL_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] ROW_LAST = YW'(IMG_H - 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(FIFO_DEPTH - 1);
  localparam logic [CW:0]   DEPTH_C  = (CW + 1)'(FIFO_DEPTH);
  localparam logic [CW:0]   ONE_C    = (CW + 1)'(1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]    state_q, state_d;
  logic          stop_q, stop_d;
  logic [AW-1:0] addr_q;
  logic [XW-1:0] col_q;
  logic [YW-1:0] row_q;

  // Tag pipeline: [3]=valid, [2]=sof, [1]=eol, [0]=eof, aligned with memory latency.
  logic [3:0]    tag_q [RD_LAT];

  logic [EW-1:0] fifo_q [FIFO_DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          vld_q;
  logic          done_q;

  logic [CW:0]   used_w;
  logic          issue_w, sof_w, eol_w, eof_w;
  logic          push_w, pop_w;
  logic [EW-1:0] head_w;
  logic          head_eof_w;
  logic          stop_now_w;

  // Occupancy plus reads still in the tag pipeline; issue is gated so every
  // outstanding read always has a FIFO slot, making backpressure lossless.
  always_comb begin
    used_w = {1'b0, cnt_q};
    for (int i = 0; i < RD_LAT; i++) begin
      used_w = used_w + {{CW{1'b0}}, tag_q[i][3]};
    end
  end

  assign sof_w   = (col_q == '0) && (row_q == '0);
  assign eol_w   = (col_q == COL_LAST);
  assign eof_w   = eol_w && (row_q == ROW_LAST);
  assign issue_w = (state_q == ST_ISSUE) && (used_w < DEPTH_C);

  assign push_w     = tag_q[RD_LAT-1][3];
  assign pop_w      = vld_q && pix_ready_i;
  assign head_w     = fifo_q[rptr_q];
  assign head_eof_w = head_w[EW-3];
  assign stop_now_w = stop_q || (CONT && stop_i);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (issue_w && eof_w && (!CONT || stop_now_w)) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        // The eof is the last item issued, so it leaves an otherwise empty pipeline.
        if (pop_w && head_eof_w && (used_w == ONE_C)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    stop_d = stop_q;
    if (state_d == ST_IDLE || state_q == ST_IDLE) begin
      stop_d = 1'b0;
    end else if (CONT && stop_i) begin
      stop_d = 1'b1;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    case ({push_w, pop_w})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge sys_clk_i or negedge sys_rst_ni) begin
    if (!sys_rst_ni) begin
      state_q <= ST_IDLE;
      stop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      stop_q  <= stop_d;
    end
  end

  // Address and row/column counters; markers come from these, not address compares.
  always_ff @(posedge sys_clk_i or negedge sys_rst_ni) begin
    if (!sys_rst_ni) begin
      addr_q <= '0;
      col_q  <= '0;
      row_q  <= '0;
    end else if (state_q == ST_IDLE && start_i) begin
      addr_q <= '0;
      col_q  <= '0;
      row_q  <= '0;
    end else if (issue_w) begin
      if (eof_w) begin
        addr_q <= '0;
        col_q  <= '0;
        row_q  <= '0;
      end else if (eol_w) begin
        addr_q <= addr_q + AW'(1);
        col_q  <= '0;
        row_q  <= row_q + YW'(1);
      end else begin
        addr_q <= addr_q + AW'(1);
        col_q  <= col_q + XW'(1);
      end
    end
  end

  always_ff @(posedge sys_clk_i or negedge sys_rst_ni) begin
    if (!sys_rst_ni) begin
      for (int i = 0; i < RD_LAT; i++) tag_q[i] <= 4'b0;
    end else begin
      tag_q[0] <= {issue_w, issue_w && sof_w, issue_w && eol_w, issue_w && eof_w};
      for (int i = 1; i < RD_LAT; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  always_ff @(posedge sys_clk_i or negedge sys_rst_ni) begin
    if (!sys_rst_ni) begin
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      vld_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      if (push_w) begin
        fifo_q[wptr_q] <= {tag_q[RD_LAT-1][2:0], mem_rdata_i};
        wptr_q <= (wptr_q == PTR_LAST) ? '0 : wptr_q + PW'(1);
      end
      if (pop_w) begin
        rptr_q <= (rptr_q == PTR_LAST) ? '0 : rptr_q + PW'(1);
      end
      cnt_q  <= cnt_d;
      vld_q  <= (cnt_d != '0);
      done_q <= pop_w && head_eof_w;
    end
  end

  assign mem_en_o     = issue_w;
  assign mem_addr_o   = addr_q;
  assign pix_data_o   = head_w[NCH*DW-1:0];
  assign pix_sof_o    = head_w[EW-1];
  assign pix_eol_o    = head_w[EW-2];
  assign pix_eof_o    = head_w[EW-3];
  assign pix_valid_o  = vld_q;
  assign busy_o       = (state_q != ST_IDLE);
  assign frame_done_o = done_q;

endmodule

// File: tb/tb_pixel_frame_src.sv
// tb/tb_pixel_frame_src.sv - scoreboard testbench for pixel_frame_src
module tb_pixel_frame_src;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start_s [4];
  logic        stop_s  [4];
  logic        ready_s [4];
  logic        mem_en_s [4];
  logic [3:0]  mem_addr_s [4];
  logic [23:0] rdata_s [4];
  logic [23:0] data_s [4];
  logic        valid_s [4];
  logic        sof_s [4];
  logic        eol_s [4];
  logic        eof_s [4];
  logic        busy_s [4];
  logic        done_s [4];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [23:0] word(input logic [3:0] a);
    logic [7:0] k;
    k = {4'b0, a};
    return {k + 8'd2, k + 8'd1, k};
  endfunction

  function automatic int lat_of(input int s);
    return (s == 1) ? 3 : ((s == 3) ? 2 : 1);
  endfunction

  // Instance 0: RD_LAT=1 single; 1: RD_LAT=3; 2: continuous RD_LAT=1; 3: RD_LAT=2.
  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int LAT  = (g == 1) ? 3 : ((g == 3) ? 2 : 1);
    localparam int CONT = (g == 2) ? 1 : 0;
    logic [23:0] pipe [LAT];
    always @(posedge clk) begin
      pipe[0] <= word(mem_addr_s[g]);
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign rdata_s[g] = pipe[LAT-1];

    pixel_frame_src #(
      .IMG_W(4), .IMG_H(3), .NCH(3), .DW(8), .AW(4),
      .RD_LAT(LAT), .CONTINUOUS(CONT)
    ) u_dut (
      .sys_clk_i   (clk),
      .sys_rst_ni  (rst_n),
      .start_i     (start_s[g]),
      .stop_i      (stop_s[g]),
      .mem_en_o    (mem_en_s[g]),
      .mem_addr_o  (mem_addr_s[g]),
      .mem_rdata_i (rdata_s[g]),
      .pix_data_o  (data_s[g]),
      .pix_valid_o (valid_s[g]),
      .pix_ready_i (ready_s[g]),
      .pix_sof_o   (sof_s[g]),
      .pix_eol_o   (eol_s[g]),
      .pix_eof_o   (eof_s[g]),
      .busy_o      (busy_s[g]),
      .frame_done_o(done_s[g])
    );
  end

  // Scoreboard entry: {sof, eol, eof, data}
  logic [26:0] exp_q [$];
  int  sel = 0;
  bit  mon_en = 1'b0;
  int  c0, rel, exp_addr, n_issue, n_xfer, n_done, n_sof;
  int  first_en, last_en, first_valid, done_rel;
  bit  stall_prev, busy_at_done;
  logic [26:0] held, cur, expv;

  always @(negedge clk) begin
    if (mon_en) begin
      rel = cyc - c0;
      cur = {sof_s[sel], eol_s[sel], eof_s[sel], data_s[sel]};
      if (mem_en_s[sel]) begin
        checks++;
        if (mem_addr_s[sel] !== 4'(exp_addr)) begin
          failures++;
          $display("FAIL mem_addr got=%0d exp=%0d", mem_addr_s[sel], exp_addr);
        end
        exp_addr = (exp_addr == 11) ? 0 : exp_addr + 1;
        if (first_en < 0) first_en = rel;
        last_en = rel;
        n_issue++;
        checks++;
        if (n_issue - n_xfer > lat_of(sel) + 2) begin
          failures++;
          $display("FAIL outstanding got=%0d max=%0d", n_issue - n_xfer, lat_of(sel) + 2);
        end
      end
      if (valid_s[sel] && first_valid < 0) first_valid = rel;
      if (stall_prev) begin
        checks++;
        if (valid_s[sel] !== 1'b1 || cur !== held) begin
          failures++;
          $display("FAIL stall_hold got=%0b/%h exp=1/%h", valid_s[sel], cur, held);
        end
      end
      if (valid_s[sel] && ready_s[sel]) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL extra_pixel got=%h exp=none", cur);
        end else begin
          expv = exp_q.pop_front();
          if (cur !== expv) begin
            failures++;
            $display("FAIL pixel got=%h exp=%h", cur, expv);
          end
        end
        n_xfer++;
        if (sof_s[sel]) n_sof++;
      end
      stall_prev = valid_s[sel] && !ready_s[sel];
      held = cur;
      if (done_s[sel]) begin
        n_done++;
        done_rel = rel;
        busy_at_done = busy_s[sel];
      end
    end
  end

  task automatic mon_reset(input int s);
    mon_en = 1'b0;
    sel = s;
    exp_q.delete();
    exp_addr = 0; n_issue = 0; n_xfer = 0; n_done = 0; n_sof = 0;
    first_en = -1; last_en = -1; first_valid = -1; done_rel = -1;
    stall_prev = 1'b0; busy_at_done = 1'b1;
    c0 = cyc;
    mon_en = 1'b1;
  endtask

  task automatic push_frames(input int n);
    for (int f = 0; f < n; f++)
      for (int k = 0; k < 12; k++)
        exp_q.push_back({k == 0, (k % 4) == 3, k == 11, word(4'(k))});
  endtask

  task automatic do_start(input int s);
    @(posedge clk); #1;
    c0 = cyc;
    start_s[s] = 1'b1;
    @(posedge clk); #1;
    start_s[s] = 1'b0;
  endtask

  task automatic wait_done(input int target, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(posedge clk); #2;
      if (n_done >= target && !busy_s[sel]) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    for (int s = 0; s < 4; s++) begin
      checks++;
      if ({mem_en_s[s], mem_addr_s[s], valid_s[s], data_s[s], sof_s[s], eol_s[s],
           eof_s[s], busy_s[s], done_s[s]} !== '0) begin
        failures++;
        $display("FAIL reset_outputs inst=%0d got_nonzero exp=0", s);
      end
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    bit ok;
    ready_s[0] = 1'b1;
    mon_reset(0);
    push_frames(1);
    do_start(0);
    wait_done(1, 100, ok);
    repeat (5) @(posedge clk);
    #2;
    checks++;
    if (!ok) begin failures++; $display("FAIL basic_timeout got=%0d exp=1", n_done); end
    checks++;
    if (first_en != 1 || last_en != 12 || n_issue != 12) begin
      failures++;
      $display("FAIL basic_issue got=%0d..%0d n=%0d exp=1..12 n=12", first_en, last_en, n_issue);
    end
    checks++;
    if (first_valid != 3) begin failures++; $display("FAIL basic_first_valid got=%0d exp=3", first_valid); end
    checks++;
    if (done_rel != 15 || n_done != 1) begin
      failures++;
      $display("FAIL basic_done got=%0d n=%0d exp=15 n=1", done_rel, n_done);
    end
    checks++;
    if (busy_at_done !== 1'b0) begin failures++; $display("FAIL basic_busy got=%0b exp=0", busy_at_done); end
    checks++;
    if (n_xfer != 12 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL basic_count got=%0d left=%0d exp=12 left=0", n_xfer, exp_q.size());
    end
  endtask

  task automatic test_backpressure();
    int pat [4] = '{1, 0, 0, 1};
    int k;
    bit ok;
    mon_reset(1);
    push_frames(1);
    ready_s[1] = 1'b1;
    @(posedge clk); #1;
    c0 = cyc;
    start_s[1] = 1'b1;
    k = 0;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      start_s[1] = 1'b0;
      ready_s[1] = pat[k % 4][0];
      k++;
      if (n_done >= 1 && !busy_s[1]) begin ok = 1'b1; break; end
    end
    ready_s[1] = 1'b1;
    repeat (5) @(posedge clk);
    #2;
    checks++;
    if (!ok || n_xfer != 12 || exp_q.size() != 0 || n_done != 1) begin
      failures++;
      $display("FAIL bp_count got=%0d done=%0d exp=12 done=1", n_xfer, n_done);
    end
  endtask

  task automatic test_continuous();
    bit ok;
    ready_s[2] = 1'b1;
    mon_reset(2);
    push_frames(3);
    do_start(2);
    for (int i = 0; i < 200 && n_xfer < 30; i++) begin
      @(posedge clk); #2;
    end
    #1;
    stop_s[2] = 1'b1;
    @(posedge clk); #1;
    stop_s[2] = 1'b0;
    wait_done(3, 200, ok);
    repeat (20) @(posedge clk);
    #2;
    checks++;
    if (!ok || n_done != 3) begin failures++; $display("FAIL cont_done got=%0d exp=3", n_done); end
    checks++;
    if (n_xfer != 36 || n_issue != 36 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL cont_count got=%0d/%0d exp=36/36", n_xfer, n_issue);
    end
    checks++;
    if (n_sof != 3) begin failures++; $display("FAIL cont_sof got=%0d exp=3", n_sof); end
    checks++;
    if (busy_s[2] !== 1'b0) begin failures++; $display("FAIL cont_idle got=%0b exp=0", busy_s[2]); end
  endtask

  task automatic test_reset_midframe();
    bit ok;
    ready_s[0] = 1'b1;
    mon_reset(0);
    push_frames(1);
    do_start(0);
    for (int i = 0; i < 100 && n_xfer < 5; i++) begin
      @(posedge clk); #2;
    end
    mon_en = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({mem_en_s[0], mem_addr_s[0], valid_s[0], data_s[0], sof_s[0], eol_s[0],
         eof_s[0], busy_s[0], done_s[0]} !== '0) begin
      failures++;
      $display("FAIL midreset_outputs got_nonzero exp=0 xfer=%0d", n_xfer);
    end
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    mon_reset(0);
    push_frames(1);
    do_start(0);
    wait_done(1, 100, ok);
    repeat (5) @(posedge clk);
    #2;
    checks++;
    if (!ok || n_xfer != 12 || exp_q.size() != 0 || n_done != 1) begin
      failures++;
      $display("FAIL midreset_restart got=%0d done=%0d exp=12 done=1", n_xfer, n_done);
    end
  endtask

  task automatic test_restart_ignored();
    bit ok;
    ready_s[0] = 1'b1;
    mon_reset(0);
    push_frames(1);
    do_start(0);
    for (int i = 0; i < 100 && n_xfer < 6; i++) begin
      @(posedge clk); #1;
    end
    start_s[0] = 1'b1;
    @(posedge clk); #1;
    start_s[0] = 1'b0;
    wait_done(1, 100, ok);
    repeat (20) @(posedge clk);
    #2;
    checks++;
    if (!ok || n_xfer != 12 || n_issue != 12 || n_done != 1 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL restart_ignored got=%0d/%0d done=%0d exp=12/12 done=1", n_xfer, n_issue, n_done);
    end
  endtask

  task automatic test_stall();
    bit ok;
    ready_s[3] = 1'b0;
    mon_reset(3);
    push_frames(1);
    do_start(3);
    repeat (19) @(posedge clk);
    #2;
    checks++;
    if (n_issue != 4) begin failures++; $display("FAIL stall_issues got=%0d exp=4", n_issue); end
    checks++;
    if (valid_s[3] !== 1'b1 || data_s[3] !== word(4'd0) || sof_s[3] !== 1'b1 || n_xfer != 0) begin
      failures++;
      $display("FAIL stall_head got=%0b/%h/%0b exp=1/%h/1", valid_s[3], data_s[3], sof_s[3], word(4'd0));
    end
    ready_s[3] = 1'b1;
    wait_done(1, 100, ok);
    repeat (5) @(posedge clk);
    #2;
    checks++;
    if (!ok || n_xfer != 12 || exp_q.size() != 0 || n_done != 1) begin
      failures++;
      $display("FAIL stall_resume got=%0d done=%0d exp=12 done=1", n_xfer, n_done);
    end
  endtask

  initial begin
    for (int s = 0; s < 4; s++) begin
      start_s[s] = 1'b0;
      stop_s[s]  = 1'b0;
      ready_s[s] = 1'b1;
    end
    test_reset();
    test_basic();
    test_backpressure();
    test_continuous();
    test_reset_midframe();
    test_restart_ignored();
    test_stall();
    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
